// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO.
// Read-mode selectors and the occupancy counter width.
package fifo_pkg;

    localparam int FWFT_MODE = 1;
    localparam int REG_MODE  = 0;

    // One extra bit so a full FIFO (count == DEPTH) is representable.
    function automatic int cnt_width(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Write/read handshake and status bundle of the synchronous FIFO.
// The producer/consumer side is master, the FIFO is slave.
interface sync_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  wr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  rd;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr, w_data, rd,
        input  r_data, empty, full, almost_empty, almost_full,
        input  count, overflow, underflow
    );

    modport slave (
        input  wr, w_data, rd,
        output r_data, empty, full, almost_empty, almost_full,
        output count, overflow, underflow
    );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and flag control for the synchronous FIFO.
// Full-depth capacity via wrapping pointers one bit wider than the address.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int AF_TH      = (1 << ADDR_WIDTH) - 2,
    parameter int AE_TH      = 1,
    localparam int CW        = cnt_width(ADDR_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  wr_i,
    input  logic                  rd_i,
    output logic                  wr_en_o,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] w_addr_o,
    output logic [ADDR_WIDTH-1:0] r_addr_o,
    output logic [CW-1:0]         count_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  almost_empty_o,
    output logic                  almost_full_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_TH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_TH);
    localparam logic [CW-1:0] ONE     = CW'(1);

    if (!(AE_TH < AF_TH && AF_TH <= DEPTH)) begin : g_bad_th
        $error("fifo_ctrl: need AE_TH < AF_TH <= DEPTH");
    end

    logic [CW-1:0] w_ptr_q, w_ptr_d;
    logic [CW-1:0] r_ptr_q, r_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          wr_ok, rd_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_C);

    // A read while full frees the slot the simultaneous write lands in.
    assign rd_ok = rd_i && !empty_o;
    assign wr_ok = wr_i && (!full_o || rd_i);

    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (clear_i) begin
            w_ptr_d = '0;
            r_ptr_d = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (wr_ok) w_ptr_d = w_ptr_q + ONE;
            if (rd_ok) r_ptr_d = r_ptr_q + ONE;
            unique case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + ONE;
                2'b01:   count_d = count_q - ONE;
                default: count_d = count_q;
            endcase
            ovf_d = ovf_q | (wr_i & ~wr_ok);
            udf_d = udf_q | (rd_i & ~rd_ok);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign wr_en_o        = rst_ni && !clear_i && wr_ok;
    assign rd_en_o        = rst_ni && !clear_i && rd_ok;
    assign w_addr_o       = w_ptr_q[ADDR_WIDTH-1:0];
    assign r_addr_o       = r_ptr_q[ADDR_WIDTH-1:0];
    assign count_o        = count_q;
    assign almost_full_o  = (count_q >= AF_C);
    assign almost_empty_o = (count_q <= AE_C);
    assign overflow_o     = ovf_q;
    assign underflow_o    = udf_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: storage array and read-data path.
// FWFT mode shows the head word combinationally; REG mode registers it on pop.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_TH      = (1 << ADDR_WIDTH) - 2,
    parameter int AE_TH      = 1,
    parameter int FWFT       = FWFT_MODE
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    sync_fifo_if.slave  f
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    if (FWFT != FWFT_MODE && FWFT != REG_MODE) begin : g_bad_mode
        $error("sync_fifo: FWFT must be 0 or 1");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_q;
    logic [ADDR_WIDTH-1:0] w_addr, r_addr;
    logic                  wr_en, rd_en;

    fifo_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .AF_TH      (AF_TH),
        .AE_TH      (AE_TH)
    ) u_ctrl (
        .clk_i          (clk),
        .rst_ni         (reset_n),
        .clear_i        (clear),
        .wr_i           (f.wr),
        .rd_i           (f.rd),
        .wr_en_o        (wr_en),
        .rd_en_o        (rd_en),
        .w_addr_o       (w_addr),
        .r_addr_o       (r_addr),
        .count_o        (f.count),
        .empty_o        (f.empty),
        .full_o         (f.full),
        .almost_empty_o (f.almost_empty),
        .almost_full_o  (f.almost_full),
        .overflow_o     (f.overflow),
        .underflow_o    (f.underflow)
    );

    // Storage is never reset; dropping the pointers discards its contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[w_addr] <= f.w_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n)   r_data_q <= '0;
        else if (rd_en) r_data_q <= mem_q[r_addr];
    end

    assign f.r_data = (FWFT == FWFT_MODE) ? mem_q[r_addr] : r_data_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench: FWFT and registered FIFOs driven in lockstep
// against a queue-based model, with directed and random phases.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       wr_s;
    logic       rd_s;
    logic [7:0] wd_s;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    int         q[$];
    bit         m_ovf;
    bit         m_udf;
    logic [7:0] m_rreg;

    always #5 clk = ~clk;

    sync_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) if1 ();
    sync_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) if0 ();

    assign if1.wr     = wr_s;
    assign if1.rd     = rd_s;
    assign if1.w_data = wd_s;
    assign if0.wr     = wr_s;
    assign if0.rd     = rd_s;
    assign if0.w_data = wd_s;

    sync_fifo #(
        .DATA_WIDTH(8), .ADDR_WIDTH(3), .AF_TH(6), .AE_TH(1), .FWFT(1)
    ) u_fwft (
        .clk(clk), .reset_n(rst_n), .clear(clr), .f(if1)
    );

    sync_fifo #(
        .DATA_WIDTH(8), .ADDR_WIDTH(3), .AF_TH(6), .AE_TH(1), .FWFT(0)
    ) u_reg (
        .clk(clk), .reset_n(rst_n), .clear(clr), .f(if0)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference behaviour for one rising edge.
    task automatic step(input bit rn, input bit cl, input bit w,
                        input logic [7:0] d, input bit r);
        bit racc, wacc;
        if (!rn) begin
            q.delete();
            m_ovf  = 0;
            m_udf  = 0;
            m_rreg = 8'h00;
        end else if (cl) begin
            q.delete();
            m_ovf = 0;
            m_udf = 0;
        end else begin
            racc = r && (q.size() != 0);
            wacc = w && ((q.size() != 8) || r);
            if (racc) m_rreg = 8'(q.pop_front());
            if (wacc) q.push_back(int'(d));
            if (w && !wacc) m_ovf = 1;
            if (r && !racc) m_udf = 1;
        end
    endtask

    task automatic cyc(input bit rn, input bit cl, input bit w,
                       input logic [7:0] d, input bit r);
        rst_n = rn;
        clr   = cl;
        wr_s  = w;
        wd_s  = d;
        rd_s  = r;
        @(posedge clk);
        step(rn, cl, w, d, r);
        #1;
    endtask

    task automatic chk_dut(input string t, input logic [3:0] cnt,
                           input logic e, input logic f,
                           input logic ae, input logic af,
                           input logic ov, input logic ud);
        int n;
        n = q.size();
        chk({t, ".count"}, 32'(cnt), n);
        chk({t, ".empty"}, 32'(e), 32'(n == 0));
        chk({t, ".full"}, 32'(f), 32'(n == 8));
        chk({t, ".aempty"}, 32'(ae), 32'(n <= 1));
        chk({t, ".afull"}, 32'(af), 32'(n >= 6));
        chk({t, ".ovf"}, 32'(ov), 32'(m_ovf));
        chk({t, ".udf"}, 32'(ud), 32'(m_udf));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk_dut("fwft", if1.count, if1.empty, if1.full,
                    if1.almost_empty, if1.almost_full,
                    if1.overflow, if1.underflow);
            chk_dut("reg", if0.count, if0.empty, if0.full,
                    if0.almost_empty, if0.almost_full,
                    if0.overflow, if0.underflow);
            if (q.size() != 0) chk("fwft.rdata", 32'(if1.r_data), q[0]);
            chk("reg.rdata", 32'(if0.r_data), 32'(m_rreg));
        end
    end

    task automatic chk_reset_vals(input string t);
        chk({t, ".cnt"}, 32'(if1.count), 0);
        chk({t, ".cnt0"}, 32'(if0.count), 0);
        chk({t, ".empty"}, 32'(if1.empty), 1);
        chk({t, ".full"}, 32'(if1.full), 0);
        chk({t, ".ae"}, 32'(if1.almost_empty), 1);
        chk({t, ".af"}, 32'(if1.almost_full), 0);
        chk({t, ".ovf"}, 32'(if1.overflow), 0);
        chk({t, ".udf"}, 32'(if1.underflow), 0);
        chk({t, ".udf0"}, 32'(if0.underflow), 0);
        chk({t, ".rdata0"}, 32'(if0.r_data), 0);
    endtask

    task automatic fill_f0;
        for (int i = 0; i < 8; i++) cyc(1, 0, 1, 8'(8'hF0 + i), 0);
    endtask

    initial begin
        bit w, r, c, rn;
        int pw, pr;

        cyc(0, 0, 0, 8'h00, 0);
        chk_en = 1'b1;
        cyc(0, 0, 1, 8'h12, 1);
        chk_reset_vals("reset");

        // Fill and drain
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 1, 8'(8'hF0 + i), 0);
            if (i == 4) chk("af_after5", 32'(if1.almost_full), 0);
            if (i == 5) chk("af_after6", 32'(if1.almost_full), 1);
        end
        chk("fill.full", 32'(if1.full), 1);
        chk("fill.cnt", 32'(if0.count), 8);
        for (int i = 0; i < 8; i++) begin
            chk("fill.fwft_rd", 32'(if1.r_data), 32'hF0 + i);
            cyc(1, 0, 0, 8'h00, 1);
            chk("fill.reg_rd", 32'(if0.r_data), 32'hF0 + i);
        end
        chk("fill.empty", 32'(if1.empty), 1);
        chk("fill.empty0", 32'(if0.empty), 1);

        // Overflow: ninth write rejected
        for (int i = 0; i < 9; i++) cyc(1, 0, 1, 8'(8'hF0 + i), 0);
        chk("ovf.flag", 32'(if1.overflow), 1);
        chk("ovf.cnt", 32'(if1.count), 8);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("ovf.last_fwft", 32'(if1.r_data), 32'hF7);
            cyc(1, 0, 0, 8'h00, 1);
        end
        chk("ovf.last_reg", 32'(if0.r_data), 32'hF7);
        chk("ovf.sticky", 32'(if0.overflow), 1);
        cyc(1, 1, 0, 8'h00, 0);
        chk("ovf.cleared", 32'(if0.overflow), 0);

        // Simultaneous read+write at full and at empty
        fill_f0();
        chk("sim.head", 32'(if1.r_data), 32'hF0);
        cyc(1, 0, 1, 8'hAA, 1);
        chk("sim.cnt", 32'(if1.count), 8);
        chk("sim.noovf", 32'(if1.overflow), 0);
        chk("sim.pop_reg", 32'(if0.r_data), 32'hF0);
        chk("sim.next_fwft", 32'(if1.r_data), 32'hF1);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("sim.aa_fwft", 32'(if1.r_data), 32'hAA);
            cyc(1, 0, 0, 8'h00, 1);
        end
        chk("sim.aa_reg", 32'(if0.r_data), 32'hAA);
        cyc(1, 0, 1, 8'h55, 1);
        chk("sim.empty_cnt", 32'(if0.count), 1);
        chk("sim.empty_udf", 32'(if0.underflow), 1);
        chk("sim.empty_data", 32'(if1.r_data), 32'h55);

        // Clear with 5 words stored
        cyc(1, 1, 0, 8'h00, 0);
        cyc(1, 0, 0, 8'h00, 1);
        for (int i = 0; i < 5; i++) cyc(1, 0, 1, 8'(8'h30 + i), 0);
        chk("clr.pre_cnt", 32'(if1.count), 5);
        cyc(1, 1, 1, 8'h99, 1);
        chk("clr.cnt", 32'(if1.count), 0);
        chk("clr.empty", 32'(if0.empty), 1);
        chk("clr.udf", 32'(if1.underflow), 0);
        chk("clr.ae", 32'(if1.almost_empty), 1);

        // Interleaved pairs across pointer wrap
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, 1, 8'(8'h10 + i), 0);
            chk("wrap.cnt", 32'(if1.count), 1);
            chk("wrap.fwft", 32'(if1.r_data), 32'h10 + i);
            cyc(1, 0, 0, 8'h00, 1);
            chk("wrap.reg", 32'(if0.r_data), 32'h10 + i);
        end

        // Reset in the middle of a burst
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 8'(8'h60 + i), 0);
        cyc(1, 0, 0, 8'h00, 1);
        cyc(0, 0, 1, 8'h77, 1);
        chk_reset_vals("midrst");

        // Random traffic, write-heavy then read-heavy
        for (int n = 0; n < 600; n++) begin
            pw = (n < 300) ? 75 : 35;
            pr = (n < 300) ? 35 : 70;
            w  = ($urandom_range(0, 99) < pw);
            r  = ($urandom_range(0, 99) < pr);
            c  = ($urandom_range(0, 49) == 0);
            rn = ($urandom_range(0, 99) != 0);
            cyc(rn, c, w, 8'($urandom_range(0, 255)), r);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 3, giving DEPTH = 2**ADDR_WIDTH entries.
REQ-003 The block SHALL have parameter AF_TH, default DEPTH-2, the almost_full threshold in words.
REQ-004 The block SHALL have parameter AE_TH, default 1, the almost_empty threshold in words.
REQ-005 The block SHALL have parameter FWFT, default 1, selecting the read mode: 1 = first-word-fall-through, 0 = registered.
REQ-006 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-008 The block SHALL have port clear, input, 1, synchronous flush.
REQ-009 The block SHALL have port wr, input, 1, write request.
REQ-010 The block SHALL have port w_data, input, DATA_WIDTH, write data.
REQ-011 The block SHALL have port rd, input, 1, read/pop request.
REQ-012 The block SHALL have port r_data, output, DATA_WIDTH, read data.
REQ-013 The block SHALL have ports empty, full, almost_empty and almost_full, each output, 1, occupancy flags.
REQ-014 The block SHALL have port count, output, ADDR_WIDTH+1, current occupancy, 0..DEPTH.
REQ-015 The block SHALL have ports overflow and underflow, each output, 1, sticky error flags.

Function
REQ-016 Capacity SHALL be the full DEPTH words, using ADDR_WIDTH+1-bit wrapping pointers; full = (count == DEPTH) and empty = (count == 0).
REQ-017 A read SHALL be accepted iff rd && !empty.
REQ-018 A write SHALL be accepted iff wr && (!full || rd).
REQ-019 When wr and rd are both asserted while full, both SHALL be accepted, count SHALL stay at DEPTH, and overflow SHALL NOT be set.
REQ-020 When wr and rd are both asserted while empty, only the write SHALL be accepted and underflow SHALL be set.
REQ-021 A rejected write SHALL leave memory, pointers and count unchanged and SHALL set overflow.
REQ-022 A rejected read SHALL leave memory, pointers and count unchanged and SHALL set underflow.
REQ-023 The count SHALL change on each edge by +1 for a write alone, -1 for a read alone, and 0 for both or neither.
REQ-024 Pointers SHALL wrap from DEPTH-1 to 0 in their address bits.
REQ-025 When FWFT=1, r_data SHALL equal mem[r_ptr] combinationally, SHALL be valid whenever !empty, and an accepted rd SHALL pop the word.
REQ-026 When FWFT=0, r_data SHALL load mem[r_ptr] on the edge of an accepted read (1-cycle latency) and SHALL hold its value otherwise.
REQ-027 The flags SHALL be decoded from the count register: almost_full = (count >= AF_TH) and almost_empty = (count <= AE_TH).
REQ-028 Once set, overflow and underflow SHALL remain asserted until reset or clear.
REQ-029 clear SHALL take priority over wr and rd; on the edge it is sampled, pointers, count, overflow and underflow SHALL go to 0, and memory contents SHALL NOT be modified.

Reset
REQ-030 Reset (reset_n = 0 at a rising edge) SHALL take priority over clear, wr and rd.
REQ-031 After reset: count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = 0, underflow = 0, and the registered r_data = 0.
REQ-032 Reset asserted mid-operation SHALL discard all stored words.

Structure
REQ-033 A shared package fifo_pkg SHALL hold the read-mode constants (FWFT_MODE, REG_MODE) and a function computing the count width.
REQ-034 Pointer, count and flag logic SHALL reside in one sub-module, fifo_ctrl; the storage array and the r_data path SHALL reside in sync_fifo.
REQ-035 Parameter legality (AE_TH < AF_TH <= DEPTH) SHALL be checked by elaboration-time assertion.

Verification
REQ-036 Bench parameters SHALL be DW=8, AW=3, AF_TH=6, AE_TH=1, run in both FWFT=1 and FWFT=0.
REQ-037 Fill test: write 0xF0..0xF7 -> full=1 and count=8 after 8th edge; almost_full rises after 6th write; then read all -> data 0xF0..0xF7 in order (FWFT=0: one cycle late); empty=1 after the last read.
REQ-038 Overflow test: write 9 words with no reads -> 9th rejected, overflow=1, count=8, and readback ends with 0xF7.
REQ-039 Simultaneous test: when full, wr=rd=1 with 0xAA -> count stays 8, 0xF0 popped, 0xAA read last; when empty, wr=rd=1 -> count=1, underflow=1.
REQ-040 Wrap test: 20 interleaved write/read pairs with incrementing data -> in-order data across pointer wrap, and count never exceeds 1.
REQ-041 Clear/reset test: clear with 5 words stored -> count=0, empty=1, flags cleared next cycle; reset_n low mid-burst -> all outputs at the values in REQ-031.
